// File: rtl/morse_pkg.sv
// Shared definitions for the Morse encoder: FSM encoding, timing multiples and code field widths.
package morse_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MARK,
      S_GAP,
      S_LGAP,
      S_WGAP
   } state_t;

   // Durations in Morse time units
   localparam int DOT        = 1;
   localparam int DASH       = 3;
   localparam int LETTER_GAP = 3;
   localparam int WORD_GAP   = 7;

   localparam int LEN_W = 3;
   localparam int PAT_W = 5;

endpackage

// File: rtl/morse_code_lut.sv
// Combinational ASCII-to-Morse lookup; pattern is left-aligned so the first element sits in the MSB (1 = dash).
module morse_code_lut
   import morse_pkg::*;
(
   input  logic [7:0]       letter,
   output logic [LEN_W-1:0] length,
   output logic [PAT_W-1:0] pattern,
   output logic             is_space,
   output logic             supported
);

   logic [7:0]             w_up;
   logic [LEN_W+PAT_W-1:0] w_code;

   // Table entries hold {length, right-aligned elements}
   always_comb begin
      w_up      = letter;
      if (letter >= 8'h61 && letter <= 8'h7A) w_up = letter - 8'h20;
      w_code    = '0;
      is_space  = 1'b0;
      supported = 1'b1;
      case (w_up)
         8'h41: w_code = {3'd2, 5'b00001};  // A .-
         8'h42: w_code = {3'd4, 5'b01000};  // B -...
         8'h43: w_code = {3'd4, 5'b01010};  // C -.-.
         8'h44: w_code = {3'd3, 5'b00100};  // D -..
         8'h45: w_code = {3'd1, 5'b00000};  // E .
         8'h46: w_code = {3'd4, 5'b00010};  // F ..-.
         8'h47: w_code = {3'd3, 5'b00110};  // G --.
         8'h48: w_code = {3'd4, 5'b00000};  // H ....
         8'h49: w_code = {3'd2, 5'b00000};  // I ..
         8'h4A: w_code = {3'd4, 5'b00111};  // J .---
         8'h4B: w_code = {3'd3, 5'b00101};  // K -.-
         8'h4C: w_code = {3'd4, 5'b00100};  // L .-..
         8'h4D: w_code = {3'd2, 5'b00011};  // M --
         8'h4E: w_code = {3'd2, 5'b00010};  // N -.
         8'h4F: w_code = {3'd3, 5'b00111};  // O ---
         8'h50: w_code = {3'd4, 5'b00110};  // P .--.
         8'h51: w_code = {3'd4, 5'b01101};  // Q --.-
         8'h52: w_code = {3'd3, 5'b00010};  // R .-.
         8'h53: w_code = {3'd3, 5'b00000};  // S ...
         8'h54: w_code = {3'd1, 5'b00001};  // T -
         8'h55: w_code = {3'd3, 5'b00001};  // U ..-
         8'h56: w_code = {3'd4, 5'b00001};  // V ...-
         8'h57: w_code = {3'd3, 5'b00011};  // W .--
         8'h58: w_code = {3'd4, 5'b01001};  // X -..-
         8'h59: w_code = {3'd4, 5'b01011};  // Y -.--
         8'h5A: w_code = {3'd4, 5'b01100};  // Z --..
         8'h30: w_code = {3'd5, 5'b11111};
         8'h31: w_code = {3'd5, 5'b01111};
         8'h32: w_code = {3'd5, 5'b00111};
         8'h33: w_code = {3'd5, 5'b00011};
         8'h34: w_code = {3'd5, 5'b00001};
         8'h35: w_code = {3'd5, 5'b00000};
         8'h36: w_code = {3'd5, 5'b10000};
         8'h37: w_code = {3'd5, 5'b11000};
         8'h38: w_code = {3'd5, 5'b11100};
         8'h39: w_code = {3'd5, 5'b11110};
         8'h20: is_space  = 1'b1;
         default: supported = 1'b0;
      endcase
   end

   assign length  = w_code[LEN_W+PAT_W-1:PAT_W];
   assign pattern = w_code[PAT_W-1:0] << (3'd5 - length);

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: accepts one ASCII character per handshake and plays its marks and gaps on signal.
module morse_encoder
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] letter,
   input  logic       valid,
   output logic       ready,
   output logic       signal,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int CW = $clog2(WORD_GAP*UNIT_CYCLES) + 1;
   // Counter reload values: a state lasting N cycles loads N-1 and exits at zero
   localparam logic [CW-1:0] C_DOT  = CW'(DOT*UNIT_CYCLES - 1);
   localparam logic [CW-1:0] C_DASH = CW'(DASH*UNIT_CYCLES - 1);
   localparam logic [CW-1:0] C_LGAP = CW'(LETTER_GAP*UNIT_CYCLES - 1);
   localparam logic [CW-1:0] C_WGAP = CW'(WORD_GAP*UNIT_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [LEN_W-1:0] r_idx, w_idx_nxt;
   logic [LEN_W-1:0] r_len, w_len_nxt;
   logic [PAT_W-1:0] r_pat, w_pat_nxt;
   logic             r_done, w_done_nxt;
   logic             r_err, w_err_nxt;

   logic [LEN_W-1:0] w_lut_len;
   logic [PAT_W-1:0] w_lut_pat;
   logic             w_lut_space;
   logic             w_lut_ok;

   morse_code_lut u_lut (
      .letter    (letter),
      .length    (w_lut_len),
      .pattern   (w_lut_pat),
      .is_space  (w_lut_space),
      .supported (w_lut_ok)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_pat   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_len   <= w_len_nxt;
         r_pat   <= w_pat_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // r_pat is shifted after each element, so r_pat[MSB] is always the current/next element
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_len_nxt   = r_len;
      w_pat_nxt   = r_pat;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (valid) begin
               if (!w_lut_ok) begin
                  w_done_nxt = 1'b1;
                  w_err_nxt  = 1'b1;
               end else if (w_lut_space) begin
                  w_state_nxt = S_WGAP;
                  w_cnt_nxt   = C_WGAP;
               end else begin
                  w_state_nxt = S_MARK;
                  w_cnt_nxt   = w_lut_pat[PAT_W-1] ? C_DASH : C_DOT;
                  w_len_nxt   = w_lut_len;
                  w_pat_nxt   = w_lut_pat;
                  w_idx_nxt   = '0;
               end
            end
         end
         S_MARK: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (r_idx + 3'd1 < r_len) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = C_DOT;
               w_idx_nxt   = r_idx + 3'd1;
               w_pat_nxt   = {r_pat[PAT_W-2:0], 1'b0};
            end else begin
               w_state_nxt = S_LGAP;
               w_cnt_nxt   = C_LGAP;
            end
         end
         S_GAP: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_state_nxt = S_MARK;
               w_cnt_nxt   = r_pat[PAT_W-1] ? C_DASH : C_DOT;
            end
         end
         S_LGAP, S_WGAP: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
         end
      endcase
   end

   assign ready  = (r_state == S_IDLE);
   assign busy   = (r_state != S_IDLE);
   assign signal = (r_state == S_MARK);
   assign done   = r_done;
   assign error  = r_err;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder at UNIT_CYCLES=4; cycle 0 is the handshake cycle.
module tb_morse_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] letter;
   logic       valid;
   logic       ready, sig_o, busy, done, error;

   int n_tests = 0;
   int n_fail  = 0;

   logic [127:0] tr;
   int           done_cyc, done_cnt, err_cyc, err_cnt;
   logic         rdy_at_done;

   morse_encoder #(.UNIT_CYCLES(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .letter (letter),
      .valid  (valid),
      .ready  (ready),
      .signal (sig_o),
      .busy   (busy),
      .done   (done),
      .error  (error)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] mk(input int lo, input int hi);
      logic [127:0] v;
      v = '0;
      for (int i = lo; i <= hi; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      tr          = '0;
      done_cyc    = 0;
      done_cnt    = 0;
      err_cyc     = 0;
      err_cnt     = 0;
      rdy_at_done = 1'b0;
   endtask

   // Called #1 after the handshake edge, i.e. during cycle 1
   task automatic capture(input int first, input int last);
      for (int k = first; k <= last; k++) begin
         tr[k] = sig_o;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc == 0) begin
               done_cyc    = k;
               rdy_at_done = ready;
            end
         end
         if (error === 1'b1) begin
            err_cnt++;
            if (err_cyc == 0) err_cyc = k;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic hs(input logic [7:0] c);
      letter = c;
      valid  = 1'b1;
      @(posedge clk); #1;
      valid  = 1'b0;
   endtask

   task automatic check_e(input string tag);
      clr();
      hs(8'h45);
      capture(1, 24);
      check({tag, "_trace"}, tr, mk(1, 4));
      check({tag, "_done_cyc"}, 128'(done_cyc), 128'(17));
      check({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
      check({tag, "_err_cnt"}, 128'(err_cnt), 128'(0));
      check({tag, "_ready_at_done"}, 128'(rdy_at_done), 128'(1));
   endtask

   initial begin
      rst_n  = 1'b0;
      valid  = 1'b0;
      letter = 8'h00;
      #3;
      check("rst_ready", 128'(ready), 128'(1));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_signal", 128'(sig_o), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_error", 128'(error), 128'(0));
      #20;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      check_e("E");

      clr();
      hs(8'h61);
      capture(1, 36);
      check("a_trace", tr, mk(1, 4) | mk(9, 20));
      check("a_done_cyc", 128'(done_cyc), 128'(33));
      check("a_err_cnt", 128'(err_cnt), 128'(0));

      clr();
      hs(8'h30);
      capture(1, 92);
      check("zero_trace", tr, mk(1, 12) | mk(17, 28) | mk(33, 44) | mk(49, 60) | mk(65, 76));
      check("zero_done_cyc", 128'(done_cyc), 128'(89));
      check("zero_done_cnt", 128'(done_cnt), 128'(1));

      clr();
      hs(8'h20);
      check("space_busy", 128'(busy), 128'(1));
      capture(1, 32);
      check("space_trace", tr, 128'(0));
      check("space_done_cyc", 128'(done_cyc), 128'(29));
      check("space_err_cnt", 128'(err_cnt), 128'(0));

      clr();
      hs(8'h23);
      check("hash_ready_c1", 128'(ready), 128'(1));
      capture(1, 4);
      check("hash_trace", tr, 128'(0));
      check("hash_done_cyc", 128'(done_cyc), 128'(1));
      check("hash_err_cyc", 128'(err_cyc), 128'(1));
      check("hash_err_cnt", 128'(err_cnt), 128'(1));
      check("hash_done_cnt", 128'(done_cnt), 128'(1));
      check("hash_ready_at_done", 128'(rdy_at_done), 128'(1));

      // valid held: E then T, T taken on E's done cycle
      clr();
      letter = 8'h45;
      valid  = 1'b1;
      @(posedge clk); #1;
      letter = 8'h54;
      capture(1, 24);
      valid = 1'b0;
      capture(25, 45);
      check("b2b_trace", tr, mk(1, 4) | mk(18, 29));
      check("b2b_first_done", 128'(done_cyc), 128'(17));
      check("b2b_done_cnt", 128'(done_cnt), 128'(2));
      check("b2b_ready_at_done", 128'(rdy_at_done), 128'(1));

      // reset mid-'T' at cycle 10
      clr();
      hs(8'h54);
      capture(1, 9);
      check("rstmid_sig_before", 128'(sig_o), 128'(1));
      rst_n = 1'b0;
      #1;
      check("rstmid_sig", 128'(sig_o), 128'(0));
      check("rstmid_busy", 128'(busy), 128'(0));
      check("rstmid_ready", 128'(ready), 128'(1));
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rstmid_done", 128'(done), 128'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      clr();
      capture(1, 20);
      check("post_rst_done_cnt", 128'(done_cnt), 128'(0));
      check("post_rst_trace", tr, 128'(0));

      check_e("E_after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
